hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle ID/EX hazard check.
- Tracks in-flight multi-cycle results with a per-register latency scoreboard:
  - getRow destination registers.
  - The line-status register, written by special ops.
- Stalls the IF/ID-stage instruction until every source it reads is ready.
- Sits beside the decode stage. Drives PC write enable, IF/ID write enable and the ID/EX bubble (NOP) insert.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_scoreboard_lat.sv | 34 +++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: register index type and decode-op classification.
package hazard_pkg;

   localparam int REG_AW_DEF     = 5;
   localparam int STATUS_REG_DEF = 9;

   typedef logic [REG_AW_DEF-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      OP_NORMAL,
      OP_SPECIAL,
      OP_GET_ROW,
      OP_SEND_ROW
   } op_class_t;

   // getRow outranks the special flag so a getRow never counts as a status writer.
   function automatic op_class_t classify(input logic special, input logic get_row,
                                          input logic send_row);
      op_class_t c;
      if (get_row)       c = OP_GET_ROW;
      else if (send_row) c = OP_SEND_ROW;
      else if (special)  c = OP_SPECIAL;
      else               c = OP_NORMAL;
      return c;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_lat.sv
// One scoreboard entry: saturating down-counter with load-wins-as-max and a freeze input.
module hazard_lat_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             nonzero,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;

   always_comb begin
      cnt_dec = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      cnt_d   = cnt_q;
      if (!hold) begin
         cnt_d = cnt_dec;
         // a re-allocation never shortens an entry that is already pending longer
         if (load && (load_val > cnt_dec)) cnt_d = load_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign nonzero = (cnt_q != '0);
   assign count   = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage latency scoreboard: stalls IF/ID until getRow/status results are readable.
// Optional stall statistics ports are built when HAZARD_STALL_STATS_EN is defined.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int REG_AW      = 5,
   parameter int STATUS_REG  = 9,
   parameter int GETROW_LAT  = 1,
   parameter int SPECIAL_LAT = 1,
   parameter int CNT_W       = $clog2(((GETROW_LAT > SPECIAL_LAT) ? GETROW_LAT : SPECIAL_LAT) + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_hold,
   input  logic              if_id_valid,
   input  logic [REG_AW-1:0] if_id_rs,
   input  logic [REG_AW-1:0] if_id_rt,
   input  logic              id_is_special,
   input  logic              id_is_get_row,
   input  logic              id_is_send_row,
   input  logic [REG_AW-1:0] id_rd,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              nop,
   output logic              busy
`ifdef HAZARD_STALL_STATS_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [15:0]       stall_events
`endif
);

   localparam logic [CNT_W-1:0] GR_LAT = CNT_W'(GETROW_LAT);
   localparam logic [CNT_W-1:0] SP_LAT = CNT_W'(SPECIAL_LAT);

   logic              hz;
   logic              issue;
   op_class_t         op_cls;
   logic [NUM_REGS-1:0] nz;
   logic [CNT_W-1:0]  cnt [NUM_REGS];

   assign nz[0]  = 1'b0;
   assign cnt[0] = '0;

   always_comb begin
      op_cls      = classify(id_is_special, id_is_get_row, id_is_send_row);
      hz          = if_id_valid &
                    (((if_id_rs != '0) & (cnt[if_id_rs] != '0)) |
                     ((if_id_rt != '0) & (cnt[if_id_rt] != '0)));
      issue       = if_id_valid & ~hz & ~pipe_hold;
      pc_write    = ~hz;
      if_id_write = ~hz;
      nop         = hz;
   end

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      logic             load;
      logic [CNT_W-1:0] load_val;

      always_comb begin
         load     = 1'b0;
         load_val = GR_LAT;
         if (issue) begin
            if ((op_cls == OP_GET_ROW) && (id_rd == REG_AW'(r))) begin
               load     = 1'b1;
               load_val = GR_LAT;
            end else if ((op_cls == OP_SPECIAL) && (r == STATUS_REG)) begin
               load     = 1'b1;
               load_val = SP_LAT;
            end
         end
      end

      hazard_lat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .hold     (pipe_hold),
         .load     (load),
         .load_val (load_val),
         .nonzero  (nz[r]),
         .count    (cnt[r])
      );
   end

   assign busy = |nz;

`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] stall_events_q, stall_events_d;
   logic        hz_q, hz_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      stall_events_d = stall_events_q;
      hz_d           = hz;
      if (hz && !pipe_hold && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'(1);
      if (hz && !hz_q && (stall_events_q != '1))      stall_events_d = stall_events_q + 16'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         stall_events_q <= '0;
         hz_q           <= 1'b0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         stall_events_q <= stall_events_d;
         hz_q           <= hz_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign stall_events = stall_events_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance at GETROW_LAT=2, one at GETROW_LAT=3, shared stimulus.
module tb_hazard_scoreboard;

   localparam int NR = 32;
   localparam int ST = 9;

   logic       clk = 1'b0;
   logic       rst, pipe_hold, if_id_valid;
   logic [4:0] if_id_rs, if_id_rt, id_rd;
   logic       id_is_special, id_is_get_row, id_is_send_row;
   logic       pc_write2, if_id_write2, nop2, busy2;
   logic       pc_write3, if_id_write3, nop3, busy3;
`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] stall_cycles2, stall_cycles3;
   logic [15:0] stall_events2, stall_events3;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard #(.GETROW_LAT(2), .SPECIAL_LAT(1)) dut2 (
      .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .if_id_valid(if_id_valid),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_is_special(id_is_special),
      .id_is_get_row(id_is_get_row), .id_is_send_row(id_is_send_row), .id_rd(id_rd),
      .pc_write(pc_write2), .if_id_write(if_id_write2), .nop(nop2), .busy(busy2)
`ifdef HAZARD_STALL_STATS_EN
      , .stall_cycles(stall_cycles2), .stall_events(stall_events2)
`endif
   );

   hazard_scoreboard #(.GETROW_LAT(3), .SPECIAL_LAT(1)) dut3 (
      .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .if_id_valid(if_id_valid),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_is_special(id_is_special),
      .id_is_get_row(id_is_get_row), .id_is_send_row(id_is_send_row), .id_rd(id_rd),
      .pc_write(pc_write3), .if_id_write(if_id_write3), .nop(nop3), .busy(busy3)
`ifdef HAZARD_STALL_STATS_EN
      , .stall_cycles(stall_cycles3), .stall_events(stall_events3)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check_b(string name, logic act, logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic check_w(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each register records the "active cycle" at which it becomes readable.
   // Active cycles only advance on edges without pipe_hold, which models the freeze.
   int     lat_g [2] = '{2, 3};
   int     lat_s = 1;
   longint active = 0;
   longint ready [2][NR];
`ifdef HAZARD_STALL_STATS_EN
   longint m_sc [2];
   longint m_se [2];
   bit     m_hzp [2];
`endif

   function automatic bit m_pending(int k, logic [4:0] r);
      return (r != 0) && (ready[k][r] > active);
   endfunction

   function automatic bit m_hz(int k);
      return if_id_valid && (m_pending(k, if_id_rs) || m_pending(k, if_id_rt));
   endfunction

   function automatic bit m_busy(int k);
      bit b = 0;
      for (int r = 1; r < NR; r++) if (ready[k][r] > active) b = 1;
      return b;
   endfunction

   function automatic longint lmax(longint a, longint b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < NR; r++) ready[k][r] = 0;
`ifdef HAZARD_STALL_STATS_EN
         m_sc[k] = 0; m_se[k] = 0; m_hzp[k] = 0;
`endif
      end
   endtask

   // Compare both instances against the model, then clock one edge and advance the model.
   task automatic step();
      bit h [2];
      bit iss [2];
      #1;
      for (int k = 0; k < 2; k++) begin
         h[k]   = m_hz(k);
         iss[k] = if_id_valid && !h[k] && !pipe_hold;
      end
      check_b("nop_l2", nop2, h[0]);
      check_b("pc_write_l2", pc_write2, !h[0]);
      check_b("if_id_write_l2", if_id_write2, !h[0]);
      check_b("busy_l2", busy2, m_busy(0));
      check_b("nop_l3", nop3, h[1]);
      check_b("pc_write_l3", pc_write3, !h[1]);
      check_b("busy_l3", busy3, m_busy(1));
`ifdef HAZARD_STALL_STATS_EN
      check_w("stall_cycles_l2", stall_cycles2, 32'(m_sc[0]));
      check_w("stall_events_l2", 32'(stall_events2), 32'(m_se[0]));
`endif
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (!pipe_hold) begin
            for (int k = 0; k < 2; k++) begin
               if (iss[k]) begin
                  if (id_is_get_row) begin
                     if (id_rd != 0) ready[k][id_rd] = lmax(ready[k][id_rd], active + 1 + lat_g[k]);
                  end else if (!id_is_send_row && id_is_special) begin
                     ready[k][ST] = lmax(ready[k][ST], active + 1 + lat_s);
                  end
               end
            end
            active++;
         end
`ifdef HAZARD_STALL_STATS_EN
         for (int k = 0; k < 2; k++) begin
            if (h[k] && !pipe_hold && m_sc[k] < 64'hFFFF_FFFF) m_sc[k]++;
            if (h[k] && !m_hzp[k] && m_se[k] < 64'hFFFF) m_se[k]++;
            m_hzp[k] = h[k];
         end
`endif
      end
      #1;
   endtask

   task automatic set_in(int v, int rs, int rt, int sp, int gr, int sr, int rd);
      rst            = 1'b0;
      pipe_hold      = 1'b0;
      if_id_valid    = 1'(v);
      if_id_rs       = 5'(rs);
      if_id_rt       = 5'(rt);
      id_is_special  = 1'(sp);
      id_is_get_row  = 1'(gr);
      id_is_send_row = 1'(sr);
      id_rd          = 5'(rd);
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      int v, rs, rt, sp, gr, sr, rd;
      bit e_nop, e_busy;
   } vec_t;

   function automatic vec_t mk(int v, int rs, int rt, int sp, int gr, int sr, int rd,
                               bit en, bit eb);
      vec_t t;
      t.v = v; t.rs = rs; t.rt = rt; t.sp = sp; t.gr = gr; t.sr = sr; t.rd = rd;
      t.e_nop = en; t.e_busy = eb;
      return t;
   endfunction

   vec_t tbl [19];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      int  stalls;
      bit  done;
      int  pool [7] = '{0, 5, 9, 3, 7, 1, 31};

      // Expectations for the GETROW_LAT=2 instance, checked before each edge.
      tbl[0]  = mk(1, 0, 0, 0, 1, 0, 5, 0, 0);  // getRow r5 issues
      tbl[1]  = mk(1, 5, 0, 0, 0, 0, 0, 1, 1);  // dependent stalls
      tbl[2]  = mk(1, 5, 0, 0, 0, 0, 0, 1, 1);  // second stall cycle
      tbl[3]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 0);  // issues
      tbl[4]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);  // special op writes status
      tbl[5]  = mk(1, 0, 9, 0, 0, 0, 0, 1, 1);  // one-cycle stall on rt=9
      tbl[6]  = mk(1, 0, 9, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0);  // sendRow allocates nothing
      tbl[8]  = mk(1, 0, 9, 0, 0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);  // getRow rd=0
      tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[11] = mk(1, 0, 0, 0, 1, 0, 7, 0, 0);  // getRow r7
      tbl[12] = mk(1, 3, 4, 0, 0, 0, 0, 0, 1);  // unrelated sources
      tbl[13] = mk(0, 7, 7, 1, 1, 0, 7, 0, 1);  // bubble: ignored, r7 drains
      tbl[14] = mk(1, 7, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 0, 1, 1, 0, 6, 0, 0);  // getRow with special flag set
      tbl[16] = mk(1, 0, 9, 0, 0, 0, 0, 0, 1);  // status not allocated
      tbl[17] = mk(1, 6, 0, 0, 0, 0, 0, 1, 1);
      tbl[18] = mk(1, 6, 0, 0, 0, 0, 0, 0, 0);

      model_reset();
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      step();
      set_in(1, 0, 0, 0, 0, 0, 0);
      #1;
      check_b("reset_pc_write", pc_write2, 1'b1);
      check_b("reset_nop", nop2, 1'b0);
      check_b("reset_busy", busy2, 1'b0);
      step();

      for (int i = 0; i < 19; i++) begin
         set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].sp, tbl[i].gr, tbl[i].sr, tbl[i].rd);
         #1;
         check_b($sformatf("tbl%0d_nop", i), nop2, tbl[i].e_nop);
         check_b($sformatf("tbl%0d_pc_write", i), pc_write2, !tbl[i].e_nop);
         check_b($sformatf("tbl%0d_busy", i), busy2, tbl[i].e_busy);
         step();
      end

      // GETROW_LAT=3 with a two-cycle freeze inside the pending window: 5 stall cycles.
      do_reset();
      set_in(1, 0, 0, 0, 1, 0, 5);
      step();
      stalls = 0;
      done   = 0;
      for (int c = 0; c < 12 && !done; c++) begin
         set_in(1, 5, 0, 0, 0, 0, 0);
         pipe_hold = (c == 1 || c == 2);
         #1;
         if (nop3) stalls++;
         else if (!pipe_hold) done = 1;
         step();
      end
      check_b("hold_seq_issued", done, 1'b1);
      check_w("hold_seq_stalls", 32'(stalls), 32'd5);

      // Reset while a dependent is stalled releases it on the next cycle.
      do_reset();
      set_in(1, 0, 0, 0, 1, 0, 5);
      step();
      set_in(1, 5, 0, 0, 0, 0, 0);
      #1;
      check_b("rst_mid_stall_before", nop2, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check_b("rst_mid_nop", nop2, 1'b0);
      check_b("rst_mid_pc_write", pc_write2, 1'b1);
      check_b("rst_mid_busy", busy2, 1'b0);
      step();

`ifdef HAZARD_STALL_STATS_EN
      do_reset();
      for (int s = 0; s < 2; s++) begin
         set_in(1, 0, 0, 0, 1, 0, 5 + s);
         step();
         for (int c = 0; c < 3; c++) begin
            set_in(1, 5 + s, 0, 0, 0, 0, 0);
            step();
         end
         set_in(1, 0, 0, 0, 0, 0, 0);
         step();
      end
      check_w("stats_cycles", stall_cycles2, 32'd4);
      check_w("stats_events", 32'(stall_events2), 32'd2);
`endif

      // Randomised traffic against the model, both latencies at once.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         set_in(($urandom_range(0, 4) != 0) ? 1 : 0,
                pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)],
                (kind == 1 || kind == 3) ? 1 : int'($urandom_range(0, 1) & (kind == 2)),
                (kind == 2) ? 1 : 0, (kind == 3) ? 1 : 0,
                pool[$urandom_range(0, 6)]);
         pipe_hold = ($urandom_range(0, 6) == 0);
         rst       = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
